// File: rtl/pe_seq_ctrl_if.sv
// pe_seq_ctrl_if
//   Bundles the handshake and status signals around the PE sequencer.
//   Channels:
//     cfg  : cfg_valid/cfg_ready, cfg_filter[23:0], cfg_len[LEN_W-1:0]
//     ifm  : ifm_valid/ifm_ready, ifm_bit
//     pkt  : pkt_valid/pkt_ready, pkt_data[25:0]  (towards the PE)
//     psum : psum_valid/psum_ready, psum_data[PSUM_W-1:0]  (from the PE)
//     out  : out_valid/out_ready, out_psum[PSUM_W-1:0], out_last
//     stat : busy, err
//   Modports:
//     master : the sequencer side (pe_seq_ctrl)
//     slave  : the surrounding system (scheduler, feeder, PE, sink)
interface pe_seq_ctrl_if #(
  parameter int PSUM_W = 12,
  parameter int LEN_W  = 8
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [23:0]       cfg_filter;
  logic [LEN_W-1:0]  cfg_len;

  logic              ifm_valid;
  logic              ifm_ready;
  logic              ifm_bit;

  logic              pkt_valid;
  logic              pkt_ready;
  logic [25:0]       pkt_data;

  logic              psum_valid;
  logic              psum_ready;
  logic [PSUM_W-1:0] psum_data;

  logic              out_valid;
  logic              out_ready;
  logic [PSUM_W-1:0] out_psum;
  logic              out_last;

  logic              busy;
  logic              err;

  modport master (
    input  cfg_valid, cfg_filter, cfg_len,
    input  ifm_valid, ifm_bit,
    input  pkt_ready,
    input  psum_valid, psum_data,
    input  out_ready,
    output cfg_ready, ifm_ready, pkt_valid, pkt_data, psum_ready,
    output out_valid, out_psum, out_last, busy, err
  );

  modport slave (
    output cfg_valid, cfg_filter, cfg_len,
    output ifm_valid, ifm_bit,
    output pkt_ready,
    output psum_valid, psum_data,
    output out_ready,
    input  cfg_ready, ifm_ready, pkt_valid, pkt_data, psum_ready,
    input  out_valid, out_psum, out_last, busy, err
  );
endinterface

// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl
//   Drives one conv PE through a 1-D, 3-tap convolution row: a clear packet,
//   a filter packet, then one ifmap packet per output position built from a
//   sliding 3-bit spike window. Each returned psum is forwarded downstream
//   with a last flag on the final position.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : pe_seq_ctrl_if.master (cfg, ifm, pkt, psum, out channels; busy, err)
// Build option:
//   PE_SEQ_TIMEOUT_EN : when defined, a PSUM_WAIT watchdog of TIMEOUT_CYCLES
//   substitutes an all-ones psum, sets the sticky err flag and keeps going.
//   When undefined, err is tied low and PSUM_WAIT waits indefinitely.
module pe_seq_ctrl #(
  parameter int PSUM_W         = 12,
  parameter int LEN_W          = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst,
  pe_seq_ctrl_if.master bus
);

  // state      | meaning
  // -----------+-------------------------------------------------------
  // S_IDLE     | waiting for a job; cfg_ready high
  // S_CLEAR    | offering the clear packet to the PE
  // S_FILT     | offering the filter packet to the PE
  // S_FILL     | taking the first two ifmap bits of the window
  // S_COLLECT  | taking the newest ifmap bit for the next position
  // S_SEND     | offering the ifmap (window) packet to the PE
  // S_PSUM_WAIT| waiting for the PE psum
  // S_OUTPUT   | offering the psum downstream
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FILT, S_FILL, S_COLLECT, S_SEND, S_PSUM_WAIT, S_OUTPUT
  } state_t;

  state_t            state, state_nxt;
  logic [23:0]       filter_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  pos_q;
  logic [2:0]        win_q;
  logic              fill_cnt_q;
  logic [PSUM_W-1:0] psum_q;
  logic              last_q;

  logic              cfg_ready, ifm_ready, pkt_valid, psum_ready, out_valid;
  logic [25:0]       pkt_data;
  logic              cfg_xfer, ifm_xfer, pkt_xfer, psum_xfer, out_xfer;
  logic              timeout;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("pe_seq_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  assign cfg_xfer  = bus.cfg_valid  & cfg_ready;
  assign ifm_xfer  = bus.ifm_valid  & ifm_ready;
  assign pkt_xfer  = pkt_valid      & bus.pkt_ready;
  assign psum_xfer = bus.psum_valid & psum_ready;
  assign out_xfer  = out_valid      & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Valids and pkt_data are functions of state and registers only, so they
  // stay stable while stalled and never follow a ready combinationally.
  always_comb begin
    state_nxt  = state;
    cfg_ready  = 1'b0;
    ifm_ready  = 1'b0;
    pkt_valid  = 1'b0;
    psum_ready = 1'b0;
    out_valid  = 1'b0;
    pkt_data   = '0;
    unique case (state)
      S_IDLE: begin
        cfg_ready = 1'b1;
        if (bus.cfg_valid && (bus.cfg_len != '0)) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        pkt_valid = 1'b1;
        if (bus.pkt_ready) state_nxt = S_FILT;
      end
      S_FILT: begin
        pkt_valid = 1'b1;
        pkt_data  = {2'b10, filter_q};
        if (bus.pkt_ready) state_nxt = S_FILL;
      end
      S_FILL: begin
        ifm_ready = 1'b1;
        if (bus.ifm_valid && fill_cnt_q) state_nxt = S_COLLECT;
      end
      S_COLLECT: begin
        ifm_ready = 1'b1;
        if (bus.ifm_valid) state_nxt = S_SEND;
      end
      S_SEND: begin
        pkt_valid = 1'b1;
        pkt_data  = {2'b11, 21'h0, win_q};
        if (bus.pkt_ready) state_nxt = S_PSUM_WAIT;
      end
      S_PSUM_WAIT: begin
        psum_ready = 1'b1;
        if (bus.psum_valid || timeout) state_nxt = S_OUTPUT;
      end
      S_OUTPUT: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nxt = last_q ? S_IDLE : S_COLLECT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filter_q   <= '0;
      len_q      <= '0;
      pos_q      <= '0;
      win_q      <= '0;
      fill_cnt_q <= 1'b0;
      psum_q     <= '0;
      last_q     <= 1'b0;
    end else begin
      if (cfg_xfer) begin
        filter_q   <= bus.cfg_filter;
        len_q      <= bus.cfg_len;
        pos_q      <= '0;
        fill_cnt_q <= 1'b0;
      end
      // Oldest bit ends up in win_q[2], which pairs with tap2 in the PE.
      if (ifm_xfer) begin
        win_q <= {win_q[1:0], bus.ifm_bit};
        if (state == S_FILL) fill_cnt_q <= ~fill_cnt_q;
      end
      if (psum_xfer) begin
        psum_q <= bus.psum_data;
        last_q <= (pos_q == (len_q - LEN_W'(1)));
      end else if (timeout) begin
        psum_q <= '1;
        last_q <= (pos_q == (len_q - LEN_W'(1)));
      end
      if (out_xfer) pos_q <= pos_q + LEN_W'(1);
    end
  end

`ifdef PE_SEQ_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] tmr_q;
  logic             err_q;

  // Down-counter loaded on entry to PSUM_WAIT; terminal count 1 means this is
  // the TIMEOUT_CYCLES-th cycle spent waiting. A psum on that same edge wins.
  assign timeout = (state == S_PSUM_WAIT) && !bus.psum_valid && (tmr_q == TMR_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q <= '0;
      err_q <= 1'b0;
    end else begin
      if ((state == S_SEND) && pkt_xfer)
        tmr_q <= TMR_W'(TIMEOUT_CYCLES);
      else if ((state == S_PSUM_WAIT) && (tmr_q != '0))
        tmr_q <= tmr_q - TMR_W'(1);
      if (timeout) err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign timeout = 1'b0;
  assign bus.err = 1'b0;
`endif

  assign bus.cfg_ready  = cfg_ready;
  assign bus.ifm_ready  = ifm_ready;
  assign bus.pkt_valid  = pkt_valid;
  assign bus.pkt_data   = pkt_data;
  assign bus.psum_ready = psum_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_psum   = psum_q;
  assign bus.out_last   = last_q;
  assign bus.busy       = (state != S_IDLE);

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// tb_pe_seq_ctrl
//   Randomized bench for pe_seq_ctrl. Expected packets and outputs come from a
//   convolution reference computed directly from the job's filter and spike
//   stream; a PE model answers ifmap packets and a downstream sink consumes
//   results, both with optional random stalls.
module tb_pe_seq_ctrl;
  localparam int PSUM_W = 12;
  localparam int LEN_W  = 8;
  localparam int TMO    = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_seq_ctrl_if #(.PSUM_W(PSUM_W), .LEN_W(LEN_W)) bus();

  pe_seq_ctrl #(.PSUM_W(PSUM_W), .LEN_W(LEN_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  logic [25:0]       exp_pkt[$];
  logic [PSUM_W:0]   exp_out[$];
  bit                bitq[$];
  bit                job_bits[$];

  bit bp = 0, pe_mute = 0, cfg_hold = 0, job_active = 0, idle_expect = 0;
  int jobs_done = 0, job_base = 0, ifm_count = 0, cfg_count = 0, outs_seen = 0;
  bit cfg_fire = 0, pkt_fire = 0, ifm_fire = 0, psum_fire = 0, out_fire = 0, out_last_fire = 0;
  logic [25:0]       pkt_word = '0;
  bit                pkt_stall = 0, out_stall = 0;
  logic [25:0]       pkt_prev = '0;
  logic [PSUM_W:0]   out_prev = '0;
  logic [23:0]       cur_filter = '0;
  bit                pe_have = 0;
  int                pe_wait = 0;
  logic [PSUM_W-1:0] pe_val = '0;
  int                pw_cyc = -1, err_cyc = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // tap2 weighs the oldest spike, tap0 the newest.
  function automatic logic [PSUM_W-1:0] conv3(input logic [23:0] f, input bit oldest,
                                               input bit middle, input bit newest);
    int s;
    s = 0;
    if (oldest) s += int'(f[23:16]);
    if (middle) s += int'(f[15:8]);
    if (newest) s += int'(f[7:0]);
    return PSUM_W'(s);
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: handshakes seen here complete on the following rising edge.
  always @(negedge clk) begin
    cfg_fire = 0; pkt_fire = 0; ifm_fire = 0; psum_fire = 0; out_fire = 0; out_last_fire = 0;
    if (rst) begin
      pkt_stall = 0;
      out_stall = 0;
    end else begin
      if (pkt_stall) begin
        check("pkt_hold_valid", 32'(bus.pkt_valid), 1);
        check("pkt_hold_data", 32'(bus.pkt_data), 32'(pkt_prev));
      end
      if (out_stall) begin
        check("out_hold_valid", 32'(bus.out_valid), 1);
        check("out_hold_data", 32'({bus.out_last, bus.out_psum}), 32'(out_prev));
      end
      if (job_active) begin
        check("cfg_ready_in_job", 32'(bus.cfg_ready), 0);
        check("busy_in_job", 32'(bus.busy), 1);
      end
      if (idle_expect) begin
        check("idle_cfg_ready", 32'(bus.cfg_ready), 1);
        check("idle_busy", 32'(bus.busy), 0);
        check("idle_pkt_valid", 32'(bus.pkt_valid), 0);
        check("idle_out_valid", 32'(bus.out_valid), 0);
      end
      if (bus.psum_ready && pw_cyc < 0) pw_cyc = cyc;
      if (bus.err && err_cyc < 0) err_cyc = cyc;

      cfg_fire = bus.cfg_valid && bus.cfg_ready;
      if (cfg_fire) cfg_count++;

      pkt_fire = bus.pkt_valid && bus.pkt_ready;
      if (pkt_fire) begin
        pkt_word = bus.pkt_data;
        check("pkt_expected", 32'(exp_pkt.size() > 0), 1);
        if (exp_pkt.size() > 0) check("pkt_data", 32'(bus.pkt_data), 32'(exp_pkt.pop_front()));
      end

      ifm_fire = bus.ifm_valid && bus.ifm_ready;
      if (ifm_fire) ifm_count++;

      psum_fire = bus.psum_valid && bus.psum_ready;

      out_fire = bus.out_valid && bus.out_ready;
      if (out_fire) begin
        out_last_fire = bus.out_last;
        outs_seen++;
        check("out_expected", 32'(exp_out.size() > 0), 1);
        if (exp_out.size() > 0)
          check("out_last_psum", 32'({bus.out_last, bus.out_psum}), 32'(exp_out.pop_front()));
      end

      pkt_stall = bus.pkt_valid && !bus.pkt_ready;
      pkt_prev  = bus.pkt_data;
      out_stall = bus.out_valid && !bus.out_ready;
      out_prev  = {bus.out_last, bus.out_psum};
    end
  end

  // Driver: PE model, ifmap feeder and downstream sink.
  always @(posedge clk) begin
    #1;
    bus.pkt_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    if (cfg_fire) begin
      cur_filter = bus.cfg_filter;
      if (!cfg_hold) bus.cfg_valid = 1'b0;
      if (bus.cfg_len != '0) job_active = 1;
    end
    if (pkt_fire && pkt_word[25:24] == 2'b11 && !pe_mute) begin
      pe_have = 1;
      pe_wait = bp ? int'($urandom_range(0, 3)) : 0;
      pe_val  = conv3(cur_filter, pkt_word[2], pkt_word[1], pkt_word[0]);
    end
    if (psum_fire) bus.psum_valid = 1'b0;
    if (pe_have) begin
      if (pe_wait == 0) begin
        bus.psum_valid = 1'b1;
        bus.psum_data  = pe_val;
        pe_have = 0;
      end else begin
        pe_wait--;
      end
    end
    if (ifm_fire) begin
      if (bitq.size() > 0) bitq.delete(0);
      bus.ifm_valid = 1'b0;
    end
    if (!bus.ifm_valid && bitq.size() > 0 && (!bp || $urandom_range(0, 2) != 0)) begin
      bus.ifm_valid = 1'b1;
      bus.ifm_bit   = bitq[0];
    end
    if (out_fire && out_last_fire) begin
      job_active = 0;
      bus.cfg_valid = 1'b0;
      jobs_done++;
    end
  end

  task automatic rand_bits(input int n);
    job_bits.delete();
    for (int i = 0; i < n + 2; i++) job_bits.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic start_job(input logic [23:0] f, input logic [LEN_W-1:0] n,
                           input bit bp_i, input bit hold);
    logic [2:0]        w;
    logic [PSUM_W-1:0] ps;
    exp_pkt.delete();
    exp_out.delete();
    if (n != '0) begin
      exp_pkt.push_back(26'h0);
      exp_pkt.push_back({2'b10, f});
      for (int k = 0; k < int'(n); k++) begin
        w  = {job_bits[k], job_bits[k+1], job_bits[k+2]};
        exp_pkt.push_back({2'b11, 21'h0, w});
        ps = pe_mute ? '1 : conv3(f, job_bits[k], job_bits[k+1], job_bits[k+2]);
        exp_out.push_back({(k == int'(n) - 1), ps});
      end
      bitq = job_bits;
    end
    bp = bp_i; cfg_hold = hold;
    ifm_count = 0; cfg_count = 0; outs_seen = 0; job_base = jobs_done;
    @(posedge clk); #2;
    bus.cfg_valid  = 1'b1;
    bus.cfg_filter = f;
    bus.cfg_len    = n;
  endtask

  task automatic finish_job(input int n);
    int guard;
    guard = 0;
    while (jobs_done == job_base && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    check("job_done", jobs_done - job_base, 1);
    repeat (3) @(negedge clk);
    check("pkt_left", exp_pkt.size(), 0);
    check("out_left", exp_out.size(), 0);
    check("ifm_consumed", ifm_count, n + 2);
    check("cfg_count", cfg_count, 1);
    check("busy_after", 32'(bus.busy), 0);
    check("cfg_ready_after", 32'(bus.cfg_ready), 1);
    if (!pe_mute) check("err_clear", 32'(bus.err), 0);
  endtask

  task automatic check_all_idle(input string tag);
    check({tag, "_pkt_valid"}, 32'(bus.pkt_valid), 0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_psum_ready"}, 32'(bus.psum_ready), 0);
    check({tag, "_ifm_ready"}, 32'(bus.ifm_ready), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_err"}, 32'(bus.err), 0);
    check({tag, "_pkt_data"}, 32'(bus.pkt_data), 0);
    check({tag, "_out_psum"}, 32'(bus.out_psum), 0);
    check({tag, "_out_last"}, 32'(bus.out_last), 0);
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout reached without summary (total=%0d bad=%0d)", n_total, n_bad);
    $fatal(1);
  end

  initial begin
    int guard;
    int n;
    bus.cfg_valid = 0; bus.cfg_filter = '0; bus.cfg_len = '0;
    bus.ifm_valid = 0; bus.ifm_bit = 0;
    bus.pkt_ready = 0; bus.psum_valid = 0; bus.psum_data = '0; bus.out_ready = 0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_idle("reset");
    @(posedge clk); #2;
    rst = 1'b0;

    // Basic job.
    job_bits = '{1, 0, 1, 1, 0};
    start_job(24'h030201, 3, 0, 0);
    finish_job(3);

    // Same job under backpressure.
    job_bits = '{1, 0, 1, 1, 0};
    start_job(24'h030201, 3, 1, 0);
    finish_job(3);

    // N = 0: nothing should happen.
    job_bits.delete();
    idle_expect = 1;
    start_job(24'($urandom), 0, 0, 0);
    guard = 0;
    while (cfg_count == 0 && guard < 50) begin @(negedge clk); guard++; end
    repeat (8) @(negedge clk);
    idle_expect = 0;
    check("n0_cfg_count", cfg_count, 1);
    check("n0_ifm", ifm_count, 0);

    // Busy lockout: cfg_valid held through the job.
    rand_bits(4);
    start_job(24'($urandom), 4, 1, 1);
    finish_job(4);
    cfg_hold = 0;

    // Random jobs.
    for (int j = 0; j < 6; j++) begin
      n = int'($urandom_range(1, 8));
      rand_bits(n);
      start_job(24'($urandom), LEN_W'(n), 1'($urandom_range(0, 1)), 0);
      finish_job(n);
    end
    rand_bits(20);
    start_job(24'($urandom), 20, 1, 0);
    finish_job(20);

    // Reset during PSUM_WAIT of position 1.
    rand_bits(3);
    start_job(24'h030201, 3, 0, 0);
    guard = 0;
    while (!(outs_seen == 1 && bus.psum_ready) && guard < 500) begin
      @(negedge clk);
      if (outs_seen >= 1) pe_mute = 1;
      guard++;
    end
    check("reached_pos1_wait", outs_seen, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    bus.cfg_valid = 0; bus.ifm_valid = 0; bus.psum_valid = 0;
    pe_have = 0; bitq.delete(); exp_pkt.delete(); exp_out.delete(); job_active = 0;
    @(posedge clk); #2;
    rst = 1'b0;
    pe_mute = 0;
    @(negedge clk);
    check_all_idle("midrst");
    check("midrst_cfg_ready", 32'(bus.cfg_ready), 1);
    job_bits = '{1, 1, 1};
    start_job(24'h030201, 1, 0, 0);
    finish_job(1);

`ifdef PE_SEQ_TIMEOUT_EN
    // PE never answers: watchdog substitutes all-ones psums.
    pe_mute = 1; pw_cyc = -1; err_cyc = -1;
    rand_bits(2);
    start_job(24'($urandom), 2, 0, 0);
    finish_job(2);
    check("err_delay", err_cyc - pw_cyc, TMO);
    check("err_sticky", 32'(bus.err), 1);
    pe_mute = 0;
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
